// File: rtl/sclk_gen.sv
// Programmable gated serial-clock burst generator with lead/trail edge strobes.
// All logic runs on clk_in; sclk and the strobes are registered together.
module sclk_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] n_cycles,
  input  logic             cpol,
  output logic             sclk,
  output logic             lead_stb,
  output logic             trail_stb,
  output logic             busy,
  output logic             done
);

  localparam int unsigned EDGE_W = CNT_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_l;
  logic [DIV_W-1:0]  cnt;
  logic [CNT_W-1:0]  n_l;
  logic              cpol_l;
  logic [EDGE_W-1:0] edges;

  logic              div_hit;
  logic [EDGE_W-1:0] edges_nxt;
  logic [EDGE_W-1:0] edges_total;
  logic              last_edge;
  logic              sclk_nxt;

  // Half-period and burst-length bookkeeping; edge target 2*n_l held in CNT_W+1 bits
  always_comb begin
    div_hit     = (cnt == div_l);
    edges_nxt   = edges + EDGE_W'(1);
    edges_total = {n_l, 1'b0};
    last_edge   = (edges_nxt == edges_total);
    sclk_nxt    = ~sclk;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      div_l     <= '0;
      n_l       <= '0;
      cpol_l    <= 1'b0;
      cnt       <= '0;
      edges     <= '0;
      sclk      <= 1'b0;
      lead_stb  <= 1'b0;
      trail_stb <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      lead_stb  <= 1'b0;
      trail_stb <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          // abort beats start; a zero-length request completes immediately
          if (start && !abort) begin
            if (n_cycles == '0) begin
              done <= 1'b1;
            end else begin
              div_l  <= div;
              n_l    <= n_cycles;
              cpol_l <= cpol;
              cnt    <= '0;
              edges  <= '0;
              state  <= RUN;
              busy   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            sclk  <= cpol_l;
            busy  <= 1'b0;
            cnt   <= '0;
            edges <= '0;
          end else if (div_hit) begin
            cnt   <= '0;
            sclk  <= sclk_nxt;
            edges <= edges_nxt;
            if (sclk_nxt != cpol_l) begin
              lead_stb <= 1'b1;
            end else begin
              trail_stb <= 1'b1;
            end
            if (last_edge) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sclk_gen.sv
// Directed self-checking bench for sclk_gen; outputs sampled on the falling edge.
module tb_sclk_gen;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 6;

  logic             clk_in;
  logic             rst;
  logic             start;
  logic             abort;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] n_cycles;
  logic             cpol;
  logic             sclk;
  logic             lead_stb;
  logic             trail_stb;
  logic             busy;
  logic             done;
  logic [4:0]       outs;

  int checks   = 0;
  int failures = 0;

  sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .div       (div),
    .n_cycles  (n_cycles),
    .cpol      (cpol),
    .sclk      (sclk),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .busy      (busy),
    .done      (done)
  );

  assign outs = {sclk, lead_stb, trail_stb, busy, done};

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={sclk,lead,trail,busy,done}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected outputs k edges after the start edge, from the burst timing formulas
  function automatic logic [4:0] exp_vec(input int k, input int d, input int n, input logic c);
    int   per;
    int   tg;
    int   total;
    logic tn;
    logic s;
    logic ld;
    logic tr;
    per   = d + 1;
    tg    = k / per;
    total = 2 * n * per;
    tn    = ((k % per) == 0);
    s     = c ^ tg[0];
    ld    = tn && tg[0];
    tr    = tn && !tg[0];
    return {s, ld, tr, (k < total), (k == total)};
  endfunction

  task automatic burst(input string tag, input int d, input int n, input logic c);
    div      = DIV_W'(d);
    n_cycles = CNT_W'(n);
    cpol     = c;
    start    = 1'b1;
    cyc();
    chk({tag, "_start"}, outs, {c, 4'b0010});
    start = 1'b0;
    for (int k = 1; k <= 2 * n * (d + 1); k++) begin
      cyc();
      chk($sformatf("%s_e%0d", tag, k), outs, exp_vec(k, d, n, c));
    end
    cyc();
    chk({tag, "_idle"}, outs, {c, 4'b0000});
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    div      = '0;
    n_cycles = '0;
    cpol     = 1'b1;
    cyc();
    cyc();
    chk("reset", outs, 5'b00000);

    rst  = 1'b0;
    cpol = 1'b0;
    cyc();
    chk("idle_cpol0", outs, 5'b00000);
    cpol = 1'b1;
    cyc();
    chk("idle_cpol1", outs, 5'b10000);

    burst("legacy_div4", 4, 2, 1'b0);
    burst("div0_cpol1", 0, 3, 1'b1);

    // zero-length burst
    cpol     = 1'b1;
    n_cycles = '0;
    start    = 1'b1;
    cyc();
    chk("n0_done", outs, 5'b10001);
    start = 1'b0;
    cyc();
    chk("n0_after", outs, 5'b10000);

    // start and abort together in IDLE
    cpol     = 1'b0;
    n_cycles = CNT_W'(2);
    start    = 1'b1;
    abort    = 1'b1;
    cyc();
    chk("start_abort", outs, 5'b00000);
    start = 1'b0;
    abort = 1'b0;
    cyc();
    chk("start_abort_after", outs, 5'b00000);

    // abort in the cycle after the 3rd toggle
    div      = DIV_W'(2);
    n_cycles = CNT_W'(4);
    cpol     = 1'b0;
    start    = 1'b1;
    cyc();
    chk("abort_start", outs, 5'b00010);
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk($sformatf("abort_run_e%0d", k), outs, exp_vec(k, 2, 4, 1'b0));
    end
    abort = 1'b1;
    cyc();
    chk("abort_hit", outs, 5'b00000);
    abort = 1'b0;
    cyc();
    chk("abort_after", outs, 5'b00000);
    burst("abort_rerun", 2, 4, 1'b0);

    // reset mid-burst
    div      = DIV_W'(3);
    n_cycles = CNT_W'(5);
    cpol     = 1'b1;
    start    = 1'b1;
    cyc();
    chk("rst_burst_start", outs, 5'b10010);
    start = 1'b0;
    repeat (6) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_mid", outs, 5'b00000);
    rst = 1'b0;
    cyc();
    chk("rst_release", outs, 5'b10000);

    // start held high; mid-burst input changes apply to the next burst
    div      = DIV_W'(1);
    n_cycles = CNT_W'(2);
    cpol     = 1'b0;
    start    = 1'b1;
    cyc();
    chk("held_start", outs, 5'b00010);
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        div      = DIV_W'(0);
        n_cycles = CNT_W'(1);
        cpol     = 1'b1;
      end
      cyc();
      chk($sformatf("held_b1_e%0d", k), outs, exp_vec(k, 1, 2, 1'b0));
    end
    cyc();
    chk("held_b2_start", outs, 5'b10010);
    start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      cyc();
      chk($sformatf("held_b2_e%0d", k), outs, exp_vec(k, 0, 1, 1'b1));
    end
    cyc();
    chk("held_idle", outs, 5'b10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sclk_gen.md
Name: sclk_gen

Overview:
Parametrised, runtime-programmable serial-clock generator and successor to the fixed divide-by-10 clock block. It produces gated SCLK bursts of a programmable number of cycles for the SX1278 SPI master, at programmable frequency and polarity. It also outputs single-cycle leading/trailing edge strobes so the shift logic runs entirely in the clk_in domain. The whole block runs on clk_in, and SCLK is a registered output.

Parameters:
DIV_W, 8, width of the half-period divisor; half period = div+1 clk_in cycles, range 1..2^DIV_W
CNT_W, 6, width of the burst length; 0..2^CNT_W-1 SCLK cycles per burst

Ports:
clk_in  input  1  system clock; all logic on its rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  burst request; sampled only in IDLE
abort  input  1  terminate the current burst
div  input  DIV_W  half-period minus 1; latched at start
n_cycles  input  CNT_W  SCLK cycles in the burst; latched at start
cpol  input  1  SCLK idle level; latched at start
sclk  output  1  serial clock, registered
lead_stb  output  1  1-cycle pulse on the edge where sclk leaves idle level
trail_stb  output  1  1-cycle pulse on the edge where sclk returns to idle level
busy  output  1  high while in RUN
done  output  1  1-cycle pulse when a burst completes normally

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE, cnt=0, edge count=0, sclk=0, lead_stb=0, trail_stb=0, busy=0, done=0. Reset overrides every other input, including mid-burst; no done pulse is generated for the aborted burst.
- State IDLE:
  - sclk <= cpol on every edge (1-cycle follow latency).
  - start=1, abort=0, n_cycles!=0 → latch div_l, n_l, cpol_l; cnt<=0; edges<=0; state<=RUN; busy<=1.
  - start=1, n_cycles=0 → stay in IDLE; done<=1 for one cycle; no sclk toggle.
  - start=1 and abort=1 in the same cycle → abort wins; start is ignored.
- State RUN, on each edge:
  - If cnt==div_l: cnt<=0, sclk<=~sclk, edges<=edges+1.
    - lead_stb<=1 if the new sclk != cpol_l.
    - trail_stb<=1 otherwise.
  - Else: cnt<=cnt+1, and both strobes are 0.
  - Strobes are registered together with sclk, so they are high in exactly the cycle following the sclk transition edge.
- Completion: on the edge that performs toggle number 2*n_l, do the final toggle (sclk returns to cpol_l, trail_stb=1), and in the same edge set state<=IDLE, busy<=0, done<=1 for one cycle.
- Abort in RUN: the next edge sets state<=IDLE, sclk<=cpol_l, busy<=0, strobes=0, done=0.
- start, div, n_cycles and cpol changes during RUN are ignored. A start asserted in the same cycle done is high is accepted (state is already IDLE), giving back-to-back bursts with a 1-cycle idle gap.
- Width rules:
  - Edge counter is CNT_W+1 bits; 2*n_l is computed without overflow.
  - cnt is DIV_W bits and never exceeds div_l.
- Timing formulas:
  - div=0 → sclk toggles every clk_in edge (fclk_in/2).
  - div=4 → fclk_in/10, matching the legacy divider.
  - Burst duration = 2*n*(div+1) clk_in cycles after the start edge.

Test Plan:
- div=4, n_cycles=2, cpol=0, start at edge E0 → sclk rises after E5, falls after E10, rises after E15, falls after E20; lead_stb high after E5 and E15; trail_stb high after E10 and E20; done high one cycle after E20; busy high from after E0 until after E20.
- div=0, n_cycles=3, cpol=1 → sclk=1,0,1,0,1,0,1 on successive cycles (6 toggles); exactly 3 lead_stb and 3 trail_stb pulses; one done.
- n_cycles=0 with start → done pulses once; busy stays 0; sclk stays at cpol.
- abort at the cycle after the 3rd toggle (div=2, n=4, cpol=0) → sclk=0 next cycle, busy=0, no done; a subsequent start runs a full 4-cycle burst.
- rst asserted mid-burst → all outputs 0 on the next edge; sclk then follows cpol=1 one cycle after rst deasserts.
- start held high through a burst with div and n changed mid-burst → first burst uses the latched values; a second burst starts on the done cycle using the new values.
